// File: rtl/present_pkg.sv
// present_pkg: shared PRESENT-80 primitives (S-box, pLayer, key updates) and decryptor FSM encoding
package present_pkg;
  localparam int NR_DEFAULT = 31;
  typedef enum logic [1:0] {IDLE, SETUP, DEC, DONE} dec_state_e;
  localparam logic [0:15][3:0] SBOX     = 64'hC56B90AD3EF84712;
  localparam logic [0:15][3:0] INV_SBOX = 64'h5EF8C12DB463079A;
  function automatic logic [63:0] s_layer(input logic [63:0] x);
    logic [63:0] r;
    for (int i = 0; i < 16; i++) r[4*i +: 4] = SBOX[x[4*i +: 4]];
    return r;
  endfunction
  function automatic logic [63:0] inv_s_layer(input logic [63:0] x);
    logic [63:0] r;
    for (int i = 0; i < 16; i++) r[4*i +: 4] = INV_SBOX[x[4*i +: 4]];
    return r;
  endfunction
  // bit i moves to 16*(i%4) + i/4, which is i*16 mod 63 with bit 63 fixed
  function automatic logic [63:0] p_layer(input logic [63:0] x);
    logic [63:0] r;
    for (int i = 0; i < 64; i++) r[(i%4)*16 + i/4] = x[i];
    return r;
  endfunction
  function automatic logic [63:0] inv_p_layer(input logic [63:0] x);
    logic [63:0] r;
    for (int i = 0; i < 64; i++) r[i] = x[(i%4)*16 + i/4];
    return r;
  endfunction
  function automatic logic [79:0] key_fwd(input logic [79:0] k, input logic [4:0] rc);
    logic [79:0] t;
    t = {k[18:0], k[79:19]};
    t[79:76] = SBOX[t[79:76]];
    t[19:15] = t[19:15] ^ rc;
    return t;
  endfunction
  function automatic logic [79:0] key_inv(input logic [79:0] k, input logic [4:0] rc);
    logic [79:0] t;
    t = k;
    t[19:15] = t[19:15] ^ rc;
    t[79:76] = INV_SBOX[t[79:76]];
    return {t[60:0], t[79:61]};
  endfunction
  function automatic logic [63:0] dec_round(input logic [63:0] s, input logic [63:0] rk);
    return inv_s_layer(inv_p_layer(s ^ rk));
  endfunction
endpackage

// File: rtl/present_dec_key.sv
// present_dec_key: key register stepping the PRESENT-80 schedule forward or backward, optional K32 cache
// Ports: CK clock, RN sync active-low reset, i_load load at start, i_fwd forward/inverse select,
//   i_step apply one update, i_commit end of forward schedule, i_key cipher key, i_rc round counter,
//   o_rk current round key (upper 64 bits), o_hit cached K32 available for i_key.
// Build option: PRESENT_DEC_KEYCACHE_EN adds the tag/K32/valid cache.
module present_dec_key
  import present_pkg::*;
(
  input  logic        CK,
  input  logic        RN,
  input  logic        i_load,
  input  logic        i_fwd,
  input  logic        i_step,
  input  logic        i_commit,
  input  logic [79:0] i_key,
  input  logic [4:0]  i_rc,
  output logic [63:0] o_rk,
  output logic        o_hit
);
  logic [79:0] r_key, w_next, w_load;
  assign w_next = i_fwd ? key_fwd(r_key, i_rc) : key_inv(r_key, i_rc);
  assign o_rk = r_key[79:16];
`ifdef PRESENT_DEC_KEYCACHE_EN
  logic [79:0] r_tag, r_k32;
  logic        r_valid;
  assign o_hit = r_valid && (i_key == r_tag);
  assign w_load = o_hit ? r_k32 : i_key;
  // tag is captured at a missing start and only becomes valid once K32 for it is stored
  always_ff @(posedge CK)
    if (!RN) begin
      r_valid <= 1'b0;
      r_tag <= '0;
      r_k32 <= '0;
    end else if (i_load && !o_hit) begin
      r_tag <= i_key;
      r_valid <= 1'b0;
    end else if (i_commit) begin
      r_k32 <= w_next;
      r_valid <= 1'b1;
    end
`else
  logic w_unused;
  assign w_unused = i_commit;
  assign o_hit = 1'b0;
  assign w_load = i_key;
`endif
  always_ff @(posedge CK)
    if (!RN) r_key <= '0;
    else if (i_load) r_key <= w_load;
    else if (i_step) r_key <= w_next;
endmodule

// File: rtl/present_dec.sv
// present_dec: iterative PRESENT-80 decryptor, one round per clock, start/ready handshake
// Ports: CK clock, RN sync active-low reset, start begin (IDLE only), ctext/key sampled on start,
//   ready one-cycle completion pulse, ptext recovered plaintext held until next completion.
// Build option: PRESENT_DEC_KEYCACHE_EN skips the forward schedule when the key repeats.
module present_dec
  import present_pkg::*;
#(
  parameter int NR = NR_DEFAULT
) (
  input  logic        CK,
  input  logic        RN,
  input  logic        start,
  input  logic [63:0] ctext,
  input  logic [79:0] key,
  output logic        ready,
  output logic [63:0] ptext
);
  localparam logic [4:0] RC_LAST = 5'(NR);
  dec_state_e  r_fsm, w_fsm_nxt;
  logic [4:0]  r_rc;
  logic [63:0] r_state, r_ptext, w_rk;
  logic        r_ready, w_load, w_fwd, w_step, w_commit, w_hit;
  present_dec_key u_key (
    .CK      (CK),
    .RN      (RN),
    .i_load  (w_load),
    .i_fwd   (w_fwd),
    .i_step  (w_step),
    .i_commit(w_commit),
    .i_key   (key),
    .i_rc    (r_rc),
    .o_rk    (w_rk),
    .o_hit   (w_hit)
  );
  always_comb begin
    w_fsm_nxt = r_fsm;
    w_load = 1'b0;
    w_fwd = 1'b0;
    w_step = 1'b0;
    w_commit = 1'b0;
    case (r_fsm)
      IDLE: begin
        w_load = start;
        w_fsm_nxt = !start ? IDLE : w_hit ? DEC : SETUP;
      end
      SETUP: begin
        w_fwd = 1'b1;
        w_step = 1'b1;
        w_commit = r_rc == RC_LAST;
        w_fsm_nxt = r_rc == RC_LAST ? DEC : SETUP;
      end
      DEC: begin
        w_step = 1'b1;
        w_fsm_nxt = r_rc == 5'd1 ? DONE : DEC;
      end
      default: w_fsm_nxt = IDLE;
    endcase
  end
  always_ff @(posedge CK)
    if (!RN) begin
      r_fsm <= IDLE;
      r_rc <= '0;
      r_state <= '0;
      r_ptext <= '0;
      r_ready <= 1'b0;
    end else begin
      r_fsm <= w_fsm_nxt;
      r_ready <= r_fsm == DONE;
      if (r_fsm == DONE) r_ptext <= r_state ^ w_rk;
      if (w_load) begin
        r_state <= ctext;
        r_rc <= w_hit ? RC_LAST : 5'd1;
      end
      if (r_fsm == SETUP) r_rc <= r_rc == RC_LAST ? RC_LAST : r_rc + 5'd1;
      if (r_fsm == DEC) begin
        r_state <= dec_round(r_state, w_rk);
        r_rc <= r_rc == 5'd1 ? 5'd1 : r_rc - 5'd1;
      end
    end
  assign ready = r_ready;
  assign ptext = r_ptext;
endmodule
